// File: rtl/ex_stage.sv
// MIPS execute stage: ALU, shifter, conditional moves, HI/LO pair,
// single-cycle multiplier and a restoring sequential divider that stalls the pipe.
module ex_stage #(
   parameter int ALUOP_W  = 8,
   parameter int DIV_ITER = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [ALUOP_W-1:0] ex_alu_op,
   input  logic [31:0]        ex_alu_src1,
   input  logic [31:0]        ex_alu_src2,
   input  logic               ex_regfile_we_i,
   input  logic [4:0]         ex_regfile_waddr_i,
   input  logic               flush,
   output logic               ex_regfile_we,
   output logic [4:0]         ex_regfile_waddr,
   output logic [31:0]        ex_alu_result,
   output logic               stallreq,
   output logic [31:0]        hi_o,
   output logic [31:0]        lo_o
);

   localparam logic [ALUOP_W-1:0] OP_AND   = ALUOP_W'(8'h24);
   localparam logic [ALUOP_W-1:0] OP_OR    = ALUOP_W'(8'h25);
   localparam logic [ALUOP_W-1:0] OP_XOR   = ALUOP_W'(8'h26);
   localparam logic [ALUOP_W-1:0] OP_NOR   = ALUOP_W'(8'h27);
   localparam logic [ALUOP_W-1:0] OP_SLL   = ALUOP_W'(8'h7C);
   localparam logic [ALUOP_W-1:0] OP_SRL   = ALUOP_W'(8'h02);
   localparam logic [ALUOP_W-1:0] OP_SRA   = ALUOP_W'(8'h03);
   localparam logic [ALUOP_W-1:0] OP_MOVZ  = ALUOP_W'(8'h0A);
   localparam logic [ALUOP_W-1:0] OP_MOVN  = ALUOP_W'(8'h0B);
   localparam logic [ALUOP_W-1:0] OP_MFHI  = ALUOP_W'(8'h10);
   localparam logic [ALUOP_W-1:0] OP_MTHI  = ALUOP_W'(8'h11);
   localparam logic [ALUOP_W-1:0] OP_MFLO  = ALUOP_W'(8'h12);
   localparam logic [ALUOP_W-1:0] OP_MTLO  = ALUOP_W'(8'h13);
   localparam logic [ALUOP_W-1:0] OP_MULT  = ALUOP_W'(8'h18);
   localparam logic [ALUOP_W-1:0] OP_MULTU = ALUOP_W'(8'h19);
   localparam logic [ALUOP_W-1:0] OP_DIV   = ALUOP_W'(8'h1A);
   localparam logic [ALUOP_W-1:0] OP_DIVU  = ALUOP_W'(8'h1B);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

   div_state_t  state_reg, state_next;
   logic [5:0]  cnt_reg, cnt_next;
   logic [31:0] rem_reg, rem_next;
   logic [31:0] quo_reg, quo_next;
   logic [31:0] dvs_reg, dvs_next;
   logic        qneg_reg, qneg_next;
   logic        rneg_reg, rneg_next;
   logic        dz_reg, dz_next;
   logic [31:0] hi_reg, hi_next;
   logic [31:0] lo_reg, lo_next;

   logic        is_div, div_signed, div_stall, div_wr;
   logic [31:0] a_abs, b_abs;
   logic [32:0] shifted;
   logic        ge;
   logic [31:0] diff;
   logic [63:0] mul_a, mul_b, product;
   logic [31:0] result;
   logic        we_calc;

   assign is_div     = (ex_alu_op == OP_DIV) || (ex_alu_op == OP_DIVU);
   assign div_signed = (ex_alu_op == OP_DIV);
   assign a_abs      = (div_signed && ex_alu_src1[31]) ? -ex_alu_src1 : ex_alu_src1;
   assign b_abs      = (div_signed && ex_alu_src2[31]) ? -ex_alu_src2 : ex_alu_src2;

   // Partial remainder can reach 33 bits after the shift; the difference only
   // needs 32 because it is kept solely when it is below the divisor.
   assign shifted = {rem_reg, quo_reg[31]};
   assign ge      = shifted >= {1'b0, dvs_reg};
   assign diff    = shifted[31:0] - dvs_reg;

   // Low 64 bits of the extended product equal the signed product.
   assign mul_a   = (ex_alu_op == OP_MULT) ? {{32{ex_alu_src1[31]}}, ex_alu_src1} : {32'b0, ex_alu_src1};
   assign mul_b   = (ex_alu_op == OP_MULT) ? {{32{ex_alu_src2[31]}}, ex_alu_src2} : {32'b0, ex_alu_src2};
   assign product = mul_a * mul_b;

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      rem_next   = rem_reg;
      quo_next   = quo_reg;
      dvs_next   = dvs_reg;
      qneg_next  = qneg_reg;
      rneg_next  = rneg_reg;
      dz_next    = dz_reg;
      div_stall  = 1'b0;
      div_wr     = 1'b0;
      if (flush) begin
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE: begin
               if (is_div) begin
                  div_stall = 1'b1;
                  qneg_next = div_signed & (ex_alu_src1[31] ^ ex_alu_src2[31]);
                  rneg_next = div_signed & ex_alu_src1[31];
                  if (ex_alu_src2 == 32'b0) begin
                     dz_next    = 1'b1;
                     state_next = DONE;
                  end else begin
                     dz_next    = 1'b0;
                     quo_next   = a_abs;
                     dvs_next   = b_abs;
                     rem_next   = 32'b0;
                     cnt_next   = 6'd0;
                     state_next = BUSY;
                  end
               end
            end
            BUSY: begin
               div_stall = 1'b1;
               rem_next  = ge ? diff : shifted[31:0];
               quo_next  = {quo_reg[30:0], ge};
               cnt_next  = cnt_reg + 6'd1;
               if (cnt_reg == 6'(DIV_ITER - 1))
                  state_next = DONE;
            end
            DONE: begin
               div_wr     = ~dz_reg;
               state_next = IDLE;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_comb begin
      hi_next = hi_reg;
      lo_next = lo_reg;
      if (!flush) begin
         if (div_wr) begin
            lo_next = qneg_reg ? -quo_reg : quo_reg;
            hi_next = rneg_reg ? -rem_reg : rem_reg;
         end else begin
            case (ex_alu_op)
               OP_MTHI:           hi_next = ex_alu_src1;
               OP_MTLO:           lo_next = ex_alu_src1;
               OP_MULT, OP_MULTU: {hi_next, lo_next} = product;
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      result  = 32'b0;
      we_calc = 1'b0;
      case (ex_alu_op)
         OP_AND:  begin result = ex_alu_src1 & ex_alu_src2;     we_calc = ex_regfile_we_i; end
         OP_OR:   begin result = ex_alu_src1 | ex_alu_src2;     we_calc = ex_regfile_we_i; end
         OP_XOR:  begin result = ex_alu_src1 ^ ex_alu_src2;     we_calc = ex_regfile_we_i; end
         OP_NOR:  begin result = ~(ex_alu_src1 | ex_alu_src2);  we_calc = ex_regfile_we_i; end
         OP_SLL:  begin result = ex_alu_src2 << ex_alu_src1[4:0]; we_calc = ex_regfile_we_i; end
         OP_SRL:  begin result = ex_alu_src2 >> ex_alu_src1[4:0]; we_calc = ex_regfile_we_i; end
         OP_SRA:  begin result = $signed(ex_alu_src2) >>> ex_alu_src1[4:0]; we_calc = ex_regfile_we_i; end
         OP_MOVZ: begin result = ex_alu_src1; we_calc = ex_regfile_we_i & (ex_alu_src2 == 32'b0); end
         OP_MOVN: begin result = ex_alu_src1; we_calc = ex_regfile_we_i & (ex_alu_src2 != 32'b0); end
         OP_MFHI: begin result = hi_reg; we_calc = ex_regfile_we_i; end
         OP_MFLO: begin result = lo_reg; we_calc = ex_regfile_we_i; end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         cnt_reg   <= 6'd0;
         rem_reg   <= 32'b0;
         quo_reg   <= 32'b0;
         dvs_reg   <= 32'b0;
         qneg_reg  <= 1'b0;
         rneg_reg  <= 1'b0;
         dz_reg    <= 1'b0;
         hi_reg    <= 32'b0;
         lo_reg    <= 32'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         rem_reg   <= rem_next;
         quo_reg   <= quo_next;
         dvs_reg   <= dvs_next;
         qneg_reg  <= qneg_next;
         rneg_reg  <= rneg_next;
         dz_reg    <= dz_next;
         hi_reg    <= hi_next;
         lo_reg    <= lo_next;
      end
   end

   assign ex_regfile_we    = ~rst & ~flush & we_calc;
   assign ex_alu_result    = rst ? 32'b0 : result;
   assign stallreq         = ~rst & div_stall;
   assign ex_regfile_waddr = ex_regfile_waddr_i;
   assign hi_o             = hi_reg;
   assign lo_o             = lo_reg;

endmodule
